// File: rtl/data_memory_responder_pkg.sv
// Shared encodings and types for the data memory responder: load/store command
// encodings, console TX state type and status-word packing.
`ifndef DATA_MEMORY_RESPONDER_DEFINES
`define DATA_MEMORY_RESPONDER_DEFINES
`define READ            1'b0
`define WRITE           1'b1
`define ENABLE          1'b1
`define DISABLE         1'b0
`define CONSOLE_ADDRESS 32'h1000_0000
`endif

package data_memory_responder_pkg;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   localparam int BYTE_LANES    = 4;
   localparam int BITS_PER_CHAR = 8;

   function automatic logic [31:0] console_status(input logic full, input logic empty);
      return {30'b0, full, empty};
   endfunction

endpackage

// File: rtl/data_memory_responder_console_uart_tx.sv
// Console byte FIFO feeding an 8N1 UART transmitter (LSB first, idle high).
module console_uart_tx
   import data_memory_responder_pkg::*;
#(
   parameter int FIFO_DEPTH   = 16,
   parameter int CLKS_PER_BIT = 868
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_push,
   input  logic [7:0] i_push_data,
   output logic       o_full,
   output logic       o_empty,
   output logic       o_overflow,
   output logic       o_uart_tx
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   generate
      if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_fifo_depth_error
         $error("FIFO_DEPTH must be a power of two and at least 2");
      end
      if (CLKS_PER_BIT < 2) begin : g_baud_error
         $error("CLKS_PER_BIT must be at least 2");
      end
   endgenerate

   logic [7:0]        r_fifo [FIFO_DEPTH];
   logic [PTR_W:0]    r_wr_ptr;
   logic [PTR_W:0]    r_rd_ptr;
   logic              r_overflow;
   tx_state_t         r_state;
   logic [BAUD_W-1:0] r_baud;
   logic [2:0]        r_bit;
   logic [7:0]        r_shift;
   logic              r_tx;

   logic w_full;
   logic w_empty;
   logic w_pop;
   logic w_push_ok;

   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                      (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
   assign w_pop     = (r_state == TX_IDLE) && !w_empty;
   // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
   assign w_push_ok = i_push && (!w_full || w_pop);

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_fifo[r_wr_ptr[PTR_W-1:0]] <= i_push_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (i_push && !w_push_ok) begin
            r_overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= TX_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
      end else begin
         case (r_state)
            TX_IDLE: begin
               r_tx   <= 1'b1;
               r_baud <= '0;
               r_bit  <= '0;
               if (w_pop) begin
                  r_shift <= r_fifo[r_rd_ptr[PTR_W-1:0]];
                  r_tx    <= 1'b0;
                  r_state <= TX_START;
               end
            end
            TX_START: begin
               if (r_baud == BAUD_LAST) begin
                  r_baud  <= '0;
                  r_tx    <= r_shift[0];
                  r_state <= TX_DATA;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            TX_DATA: begin
               if (r_baud == BAUD_LAST) begin
                  r_baud <= '0;
                  if (r_bit == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= TX_STOP;
                  end else begin
                     r_bit   <= r_bit + 1'b1;
                     r_shift <= {1'b0, r_shift[7:1]};
                     r_tx    <= r_shift[1];
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            TX_STOP: begin
               r_tx <= 1'b1;
               if (r_baud == BAUD_LAST) begin
                  r_baud  <= '0;
                  r_state <= TX_IDLE;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            default: begin
               r_tx    <= 1'b1;
               r_state <= TX_IDLE;
            end
         endcase
      end
   end

   assign o_full     = w_full;
   assign o_empty    = w_empty;
   assign o_overflow = r_overflow;
   assign o_uart_tx  = r_tx;

endmodule

// File: rtl/data_memory_responder.sv
// Target side of the core's data memory port: word RAM with byte-lane writes,
// combinational reads, and a console TX/status register backed by a UART.
module data_memory_responder
   import data_memory_responder_pkg::*;
#(
   parameter int          MEM_DEPTH_WORDS = 4096,
   parameter logic [31:0] CONSOLE_ADDRESS = `CONSOLE_ADDRESS,
   parameter int          FIFO_DEPTH      = 16,
   parameter int          CLKS_PER_BIT    = 868
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        data_memory_interface_enable,
   input  logic        data_memory_interface_state,
   input  logic [31:0] data_memory_interface_address,
   input  logic [3:0]  data_memory_interface_frame_mask,
   input  logic [31:0] data_memory_interface_write_data,
   output logic [31:0] data_memory_interface_read_data,
   output logic        uart_tx,
   output logic        console_overflow
);

   localparam int          IDX_W     = $clog2(MEM_DEPTH_WORDS);
   localparam logic [32:0] RAM_BYTES = 33'(MEM_DEPTH_WORDS) << 2;

   generate
      if (MEM_DEPTH_WORDS < 2 || (MEM_DEPTH_WORDS & (MEM_DEPTH_WORDS - 1)) != 0) begin : g_depth_error
         $error("MEM_DEPTH_WORDS must be a power of two and at least 2");
      end
      if ({1'b0, CONSOLE_ADDRESS[31:2], 2'b00} < RAM_BYTES) begin : g_overlap_error
         $error("CONSOLE_ADDRESS overlaps the RAM address range");
      end
   endgenerate

   logic [31:0] r_ram [MEM_DEPTH_WORDS];

   logic             w_access;
   logic             w_is_read;
   logic             w_is_write;
   logic             w_ram_hit;
   logic             w_console_hit;
   logic             w_ram_we;
   logic             w_push;
   logic [IDX_W-1:0] w_word_idx;
   logic [BYTE_LANES-1:0] w_lane_en;
   logic             w_full;
   logic             w_empty;
   logic             w_overflow;
   logic             w_uart_tx;
   logic [31:0]      w_read_data;

   assign w_access      = (data_memory_interface_enable == `ENABLE);
   assign w_is_read     = w_access && (data_memory_interface_state == `READ);
   assign w_is_write    = w_access && (data_memory_interface_state == `WRITE);
   assign w_ram_hit     = ({1'b0, data_memory_interface_address} < RAM_BYTES);
   assign w_console_hit = (data_memory_interface_address[31:2] == CONSOLE_ADDRESS[31:2]);
   assign w_word_idx    = data_memory_interface_address[IDX_W+1:2];
   assign w_ram_we      = w_is_write && w_ram_hit;
   assign w_push        = w_is_write && w_console_hit && data_memory_interface_frame_mask[3];

   // Mask bit 3 owns the least significant byte; the lanes run in reverse.
   generate
      for (genvar gi = 0; gi < BYTE_LANES; gi++) begin : g_lane
         assign w_lane_en[gi] = data_memory_interface_frame_mask[BYTE_LANES-1-gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (w_ram_we) begin
         for (int i = 0; i < BYTE_LANES; i++) begin
            if (w_lane_en[i]) begin
               r_ram[w_word_idx][8*i +: 8] <= data_memory_interface_write_data[8*i +: 8];
            end
         end
      end
   end

   always_comb begin
      w_read_data = '0;
      if (w_is_read) begin
         if (w_ram_hit) begin
            w_read_data = r_ram[w_word_idx];
         end else if (w_console_hit) begin
            w_read_data = console_status(w_full, w_empty);
         end
      end
   end

   console_uart_tx #(
      .FIFO_DEPTH   (FIFO_DEPTH),
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_console (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_push),
      .i_push_data (data_memory_interface_write_data[BITS_PER_CHAR-1:0]),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_overflow  (w_overflow),
      .o_uart_tx   (w_uart_tx)
   );

   assign data_memory_interface_read_data = w_read_data;
   assign uart_tx                         = w_uart_tx;
   assign console_overflow                = w_overflow;

endmodule
